// File: rtl/axis_pkt_pkg.sv
// Shared constants, state encoding and header layout for the AXI-Stream packetizer.
package axis_pkt_pkg;
    localparam logic [15:0] HDR_MAGIC = 16'hA55A;
    localparam int LEN_W  = 8;
    localparam int SEQ_W  = 8;
    localparam int DATA_W = 32;
    localparam int DEST_W = 2;

    localparam int HDR_LEN_LSB   = 0;
    localparam int HDR_SEQ_LSB   = HDR_LEN_LSB + LEN_W;
    localparam int HDR_MAGIC_LSB = 16;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    // Header word: {magic, seq, len}
    function automatic logic [DATA_W-1:0] make_hdr(input logic [SEQ_W-1:0] seq,
                                                   input logic [LEN_W-1:0] len);
        logic [DATA_W-1:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 16]  = HDR_MAGIC;
        w[HDR_SEQ_LSB +: SEQ_W] = seq;
        w[HDR_LEN_LSB +: LEN_W] = len;
        return w;
    endfunction
endpackage

// File: rtl/axi_stream_packetizer_if.sv
// AXI-Stream bundle; master drives payload/sideband, slave drives tready.
interface axis_if;
    import axis_pkt_pkg::*;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [DEST_W-1:0] tdest;
    logic [3:0]        tkeep;
    logic [3:0]        tstrb;
    logic [7:0]        tid;

    modport master (output tvalid, tdata, tlast, tdest, tkeep, tstrb, tid, input tready);
    modport slave  (input tvalid, tdata, tlast, tdest, tkeep, tstrb, tid, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-stage registered AXI-Stream slice; accepts a new beat whenever empty or draining.
module axis_out_reg
    import axis_pkt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [DEST_W-1:0] ld_dest,
    output logic              ld_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic [DEST_W-1:0] dest,
    input  logic              ready
);
    assign ld_ready = !valid || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
            dest  <= '0;
        end else if (ld_ready) begin
            valid <= ld_valid;
            if (ld_valid) begin
                data <= ld_data;
                last <= ld_last;
                dest <= ld_dest;
            end
        end
    end
endmodule

// File: rtl/axi_stream_packetizer.sv
// Frames a continuous word stream into {header, len payload words} packets with tlast and tdest.
module axi_stream_packetizer
    import axis_pkt_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    input  logic [DEST_W-1:0] cfg_dest,
    axis_if.slave             s_axis,
    axis_if.master            m_axis,
    output logic [15:0]       frame_count,
    output logic              busy
);
    state_t            state, state_n;
    logic [LEN_W-1:0]  len_q, len_n, beat_q, beat_n;
    logic [SEQ_W-1:0]  seq_q, seq_n;
    logic [DEST_W-1:0] dest_q, dest_n;
    logic              load, push, push_last, s_ready, last_beat;
    logic [DATA_W-1:0] push_data;

    assign last_beat = (beat_q == len_q - LEN_W'(1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= IDLE;
            len_q  <= '0;
            beat_q <= '0;
            seq_q  <= '0;
            dest_q <= '0;
        end else begin
            state  <= state_n;
            len_q  <= len_n;
            beat_q <= beat_n;
            seq_q  <= seq_n;
            dest_q <= dest_n;
        end
    end

    always_comb begin
        state_n   = state;
        len_n     = len_q;
        beat_n    = beat_q;
        seq_n     = seq_q;
        dest_n    = dest_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_data = make_hdr(seq_q, len_q);
        s_ready   = 1'b0;
        case (state)
            IDLE: begin
                // Only open a frame once a payload word is actually waiting.
                if (enable && s_axis.tvalid) begin
                    state_n = HDR;
                    len_n   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
                    dest_n  = cfg_dest;
                end
            end
            HDR: begin
                if (load) begin
                    push    = 1'b1;
                    seq_n   = seq_q + SEQ_W'(1);
                    state_n = PAY;
                end
            end
            PAY: begin
                s_ready   = load;
                push_data = s_axis.tdata;
                if (load && s_axis.tvalid) begin
                    push = 1'b1;
                    if (last_beat) begin
                        push_last = 1'b1;
                        beat_n    = '0;
                        if (enable && s_axis.tvalid) begin
                            state_n = HDR;
                            len_n   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
                            dest_n  = cfg_dest;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        beat_n = beat_q + LEN_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    axis_out_reg u_out (
        .clk      (aclk),
        .rst_n    (aresetn),
        .ld_valid (push),
        .ld_data  (push_data),
        .ld_last  (push_last),
        .ld_dest  (dest_q),
        .ld_ready (load),
        .valid    (m_axis.tvalid),
        .data     (m_axis.tdata),
        .last     (m_axis.tlast),
        .dest     (m_axis.tdest),
        .ready    (m_axis.tready)
    );

    // A frame is complete only when its tlast beat leaves the output register.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            frame_count <= '0;
        else if (m_axis.tvalid && m_axis.tready && m_axis.tlast)
            frame_count <= frame_count + 16'd1;
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tkeep  = 4'b1111;
    assign m_axis.tstrb  = 4'b1111;
    assign m_axis.tid    = 8'h00;
    assign busy          = (state != IDLE);

    logic unused_s;
    assign unused_s = ^{s_axis.tlast, s_axis.tdest, s_axis.tkeep, s_axis.tstrb, s_axis.tid};
endmodule

// File: tb/tb_axi_stream_packetizer.sv
// Directed bench for axi_stream_packetizer: framing, backpressure, enable drop, reset, seq wrap.
module tb_axi_stream_packetizer;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [7:0]  cfg_pkt_len;
    logic [1:0]  cfg_dest;
    logic [15:0] frame_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cap_data[$];
    logic        cap_last[$];
    logic [1:0]  cap_dest[$];
    logic [31:0] word_n;
    logic [23:0] pat;

    axis_if s_if();
    axis_if m_if();

    axi_stream_packetizer dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .enable      (enable),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_dest    (cfg_dest),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample handshakes at the falling edge, then advance one clock.
    task automatic tick();
        logic sh, mh;
        #4;
        sh = s_if.tvalid && s_if.tready;
        mh = m_if.tvalid && m_if.tready;
        if (mh === 1'b1) begin
            cap_data.push_back(m_if.tdata);
            cap_last.push_back(m_if.tlast);
            cap_dest.push_back(m_if.tdest);
        end
        @(posedge aclk);
        #1;
        if (sh === 1'b1) begin
            word_n      = word_n + 32'd1;
            s_if.tdata  = word_n;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
        cap_dest.delete();
    endtask

    task automatic do_reset();
        aresetn     = 1'b0;
        enable      = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        ticks(2);
        aresetn = 1'b1;
        clear_cap();
    endtask

    task automatic start(input logic [31:0] base, input logic [7:0] len, input logic [1:0] dest);
        word_n      = base;
        s_if.tdata  = base;
        cfg_pkt_len = len;
        cfg_dest    = dest;
        enable      = 1'b1;
        s_if.tvalid = 1'b1;
    endtask

    initial begin
        s_if.tlast = 1'b0; s_if.tdest = 2'd0; s_if.tkeep = 4'hF; s_if.tstrb = 4'hF; s_if.tid = 8'h00;
        s_if.tdata = 32'h0; word_n = 32'h0; cfg_pkt_len = 8'd4; cfg_dest = 2'd0;
        pat = 24'b1010_0110_1100_1010_0101_1011;

        // Reset state
        do_reset();
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_tdata",  m_if.tdata, 32'h0);
        chk("rst_tlast",  m_if.tlast, 1'b0);
        chk("rst_fc",     frame_count, 16'd0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_sready", s_if.tready, 1'b0);
        chk("tkeep",      m_if.tkeep, 4'hF);
        chk("tstrb",      m_if.tstrb, 4'hF);
        chk("tid",        m_if.tid, 8'h00);

        // Basic framing, len=4; cfg changed mid-frame applies to next frame only
        start(32'h1000_0000, 8'd4, 2'd2);
        ticks(3);
        cfg_pkt_len = 8'd2;
        cfg_dest    = 2'd1;
        ticks(6);
        chk("t1_hdr0",   cap_data[0], 32'hA55A_0004);
        chk("t1_dest0",  cap_dest[0], 2'd2);
        chk("t1_w0",     cap_data[1], 32'h1000_0000);
        chk("t1_w2",     cap_data[3], 32'h1000_0002);
        chk("t1_w2last", cap_last[3], 1'b0);
        chk("t1_w3",     cap_data[4], 32'h1000_0003);
        chk("t1_w3last", cap_last[4], 1'b1);
        chk("t1_hdr1",   cap_data[5], 32'hA55A_0102);
        chk("t1_dest1",  cap_dest[5], 2'd1);
        chk("t1_fc",     frame_count, 16'd1);

        // Reset for one cycle mid-payload
        tick();
        chk("t5_busy_pre", busy, 1'b1);
        aresetn = 1'b0;
        tick();
        chk("t5_tvalid", m_if.tvalid, 1'b0);
        chk("t5_fc",     frame_count, 16'd0);
        chk("t5_busy",   busy, 1'b0);
        aresetn = 1'b1;
        clear_cap();
        ticks(3);
        chk("t5_hdr_seq0", cap_data[0], 32'hA55A_0002);

        // len=0 behaves as len=1
        do_reset();
        start(32'hB000_0000, 8'd0, 2'd0);
        ticks(8);
        chk("t2_hdr0",  cap_data[0], 32'hA55A_0001);
        chk("t2_hlast", cap_last[0], 1'b0);
        chk("t2_w0",    cap_data[1], 32'hB000_0000);
        chk("t2_w0l",   cap_last[1], 1'b1);
        chk("t2_hdr1",  cap_data[2], 32'hA55A_0101);
        chk("t2_w1",    cap_data[3], 32'hB000_0001);
        chk("t2_w1l",   cap_last[3], 1'b1);
        chk("t2_hdr2",  cap_data[4], 32'hA55A_0201);

        // Downstream backpressure, len=3
        do_reset();
        start(32'hC000_0000, 8'd3, 2'd3);
        for (int i = 0; i < 24; i++) begin
            logic        stall, pl;
            logic [31:0] pd;
            m_if.tready = pat[i];
            #2;
            stall = m_if.tvalid && !m_if.tready;
            pd    = m_if.tdata;
            pl    = m_if.tlast;
            if (stall) chk("t3_sready_full", s_if.tready, 1'b0);
            tick();
            if (stall) begin
                chk("t3_hold_data", m_if.tdata, pd);
                chk("t3_hold_last", m_if.tlast, pl);
            end
        end
        m_if.tready = 1'b1;
        chk("t3_hdr0",  cap_data[0], 32'hA55A_0003);
        chk("t3_dest",  cap_dest[0], 2'd3);
        chk("t3_w0",    cap_data[1], 32'hC000_0000);
        chk("t3_w1",    cap_data[2], 32'hC000_0001);
        chk("t3_w2",    cap_data[3], 32'hC000_0002);
        chk("t3_w2l",   cap_last[3], 1'b1);
        chk("t3_w1l",   cap_last[2], 1'b0);
        chk("t3_hdr1",  cap_data[4], 32'hA55A_0103);
        chk("t3_w3",    cap_data[5], 32'hC000_0003);

        // enable dropped during beat 2 of 4: frame completes then idles
        do_reset();
        start(32'hD000_0000, 8'd4, 2'd0);
        ticks(3);
        enable = 1'b0;
        ticks(8);
        chk("t4_beats",  cap_data.size(), 32'd5);
        chk("t4_hdr",    cap_data[0], 32'hA55A_0004);
        chk("t4_w3",     cap_data[4], 32'hD000_0003);
        chk("t4_w3l",    cap_last[4], 1'b1);
        chk("t4_busy",   busy, 1'b0);
        chk("t4_sready", s_if.tready, 1'b0);
        chk("t4_tvalid", m_if.tvalid, 1'b0);
        chk("t4_fc",     frame_count, 16'd1);

        // 256 frames of len=1: sequence wraps
        do_reset();
        start(32'hE000_0000, 8'd1, 2'd0);
        ticks(515);
        chk("t6_fc",     frame_count, 16'd256);
        chk("t6_w0",     cap_data[1], 32'hE000_0000);
        chk("t6_hdrff",  cap_data[510], 32'hA55A_FF01);
        chk("t6_w255",   cap_data[511], 32'hE000_00FF);
        chk("t6_w255l",  cap_last[511], 1'b1);
        chk("t6_hdr00",  cap_data[512], 32'hA55A_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
